// File: rtl/pr_decouple_pkg.sv
// rtl/pr_decouple_pkg.sv - state encoding shared by the PR decouple sequencer
package pr_decouple_pkg;

  localparam int ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_DRAIN     = 2'd1,
    ST_DECOUPLED = 2'd2,
    ST_SETTLE    = 2'd3
  } state_e;

endpackage

// File: rtl/pr_decouple_chan.sv
// rtl/pr_decouple_chan.sv - one socket's request/drain/decoupled/settle/release FSM
// Optional drain timeout enabled by PR_DECOUPLE_DRAIN_TIMEOUT_EN.
module pr_decouple_chan
  import pr_decouple_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_i,
  input  logic            busy_i,
  input  logic            load_done_i,
  input  logic            load_err_i,
  output logic            decouple_o,
  output logic            drained_o,
  output logic            err_o,
  output logic            timeout_o,
  output logic [ST_W-1:0] state_o
);

`ifdef PR_DECOUPLE_DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_e           st_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             decouple_q;
  logic             drained_q;
  logic             err_q;
  logic             timeout_q;

  // Saturating increment: a stalled drain must never wrap back into the timeout window.
  assign cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= ST_IDLE;
      cnt_q      <= '0;
      decouple_q <= 1'b0;
      drained_q  <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (req_i) begin
            st_q       <= ST_DRAIN;
            cnt_q      <= '0;
            decouple_q <= 1'b1;
          end
        end
        ST_DRAIN: begin
          cnt_q <= cnt_d;
          if (!busy_i) begin
            st_q      <= ST_DECOUPLED;
            cnt_q     <= '0;
            drained_q <= 1'b1;
          end else if (TO_EN && cnt_q == TO_LAST) begin
            st_q      <= ST_DECOUPLED;
            cnt_q     <= '0;
            drained_q <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        ST_DECOUPLED: begin
          // A done in the same cycle as an error means the retry succeeded; drop the error.
          if (load_done_i) begin
            cnt_q     <= '0;
            drained_q <= 1'b0;
            if (SETTLE_CYCLES == 0) begin
              st_q       <= ST_IDLE;
              decouple_q <= 1'b0;
            end else begin
              st_q <= ST_SETTLE;
            end
          end else if (load_err_i) begin
            err_q <= 1'b1;
          end
        end
        ST_SETTLE: begin
          cnt_q <= cnt_d;
          if (cnt_q == SETTLE_LAST) begin
            st_q       <= ST_IDLE;
            cnt_q      <= '0;
            decouple_q <= 1'b0;
          end
        end
        default: begin
          st_q       <= ST_IDLE;
          cnt_q      <= '0;
          decouple_q <= 1'b0;
          drained_q  <= 1'b0;
        end
      endcase
    end
  end

  assign decouple_o = decouple_q;
  assign drained_o  = drained_q;
  assign err_o      = err_q;
  assign timeout_o  = timeout_q;
  assign state_o    = st_q;

endmodule

// File: rtl/pr_decouple_seq.sv
// rtl/pr_decouple_seq.sv - per-virtual-socket decouple sequencer around partial reconfiguration
// Optional drain timeout enabled by PR_DECOUPLE_DRAIN_TIMEOUT_EN.
module pr_decouple_seq
  import pr_decouple_pkg::*;
#(
  parameter int NUM_VS        = 2,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_VS-1:0]      vs_req,
  input  logic [NUM_VS-1:0]      vs_busy,
  input  logic [NUM_VS-1:0]      vs_load_done,
  input  logic [NUM_VS-1:0]      vs_load_err,
  output logic [NUM_VS-1:0]      vs_decouple,
  output logic [NUM_VS-1:0]      vs_drained,
  output logic [NUM_VS-1:0]      vs_err,
  output logic [NUM_VS-1:0]      vs_timeout,
  output logic [2*NUM_VS-1:0]    vs_state
);

  for (genvar g = 0; g < NUM_VS; g++) begin : g_chan
    pr_decouple_chan #(
      .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .req_i       (vs_req[g]),
      .busy_i      (vs_busy[g]),
      .load_done_i (vs_load_done[g]),
      .load_err_i  (vs_load_err[g]),
      .decouple_o  (vs_decouple[g]),
      .drained_o   (vs_drained[g]),
      .err_o       (vs_err[g]),
      .timeout_o   (vs_timeout[g]),
      .state_o     (vs_state[ST_W*g +: ST_W])
    );
  end

endmodule
